// File: rtl/shift_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_load_sequencer
// Description : Small word FIFO feeding a fixed-period load sequencer. Each
//               slot issues a one-cycle Load strobe with the FIFO head on D
//               and then waits out the rest of the PERIOD-cycle slot while
//               the downstream 4-bit shift register shifts.
//               Optional feature macro: SHIFT_SEQ_COUNT_EN adds an 8-bit
//               wrapping Load_Count output.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_load_sequencer #(
  parameter int DEPTH  = 4,   // FIFO capacity, power of two, 2..16
  parameter int PERIOD = 4    // clocks per load slot, 2..255
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       In_Valid,
  input  logic [3:0] In_Data,
  output logic       In_Ready,
  output logic       Load,
  output logic [3:0] D,
  output logic       Busy,
  output logic [4:0] Level
`ifdef SHIFT_SEQ_COUNT_EN
  ,
  output logic [7:0] Load_Count
`endif
);

  localparam int             c_AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]     c_DEPTH       = 5'(DEPTH);
  localparam logic [7:0]     c_SLOT_RELOAD = 8'(PERIOD - 2);
  localparam logic [c_AW-1:0] c_PTR_ONE    = c_AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t          r_state;
  logic [7:0]      r_count;
  logic [c_AW-1:0] r_wrPtr;
  logic [c_AW-1:0] r_rdPtr;
  logic [3:0]      r_mem [DEPTH];
  logic            w_push;
  logic            w_pop;

  // Ready depends only on the registered occupancy, so a pop on the same
  // edge never frees a slot for the word being offered in that cycle.
  assign In_Ready = (Level != c_DEPTH);
  assign w_push   = In_Valid && In_Ready;

  // A slot starts from IDLE or at the end of a slot, judged on the occupancy
  // before this edge; a word pushed into an empty FIFO waits one cycle.
  assign w_pop = (Level != 5'd0) &&
                 ((r_state == ST_IDLE) ||
                  ((r_state == ST_SHIFT) && (r_count == 8'd0)));

  // FIFO storage: written at the tail on every accepted word.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= In_Data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      Level   <= 5'd0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   Level <= Level + 5'd1;
        2'b01:   Level <= Level - 5'd1;
        default: Level <= Level;
      endcase
    end
  end

  // Slot sequencer with registered Load, D and Busy outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_count <= 8'd0;
      Load    <= 1'b0;
      D       <= 4'b0000;
      Busy    <= 1'b0;
    end else begin
      Load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_LOAD;
            Load    <= 1'b1;
            D       <= r_mem[r_rdPtr];
            Busy    <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_SHIFT;
          r_count <= c_SLOT_RELOAD;
          Busy    <= 1'b1;
        end
        ST_SHIFT: begin
          if (r_count == 8'd0) begin
            if (w_pop) begin
              r_state <= ST_LOAD;
              Load    <= 1'b1;
              D       <= r_mem[r_rdPtr];
              Busy    <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              Busy    <= 1'b0;
            end
          end else begin
            r_count <= r_count - 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHIFT_SEQ_COUNT_EN
  // Count every slot start; the 8-bit counter wraps from 255 to 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Load_Count <= 8'd0;
    end else if (w_pop) begin
      Load_Count <= Load_Count + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_load_sequencer
// Description : Randomised and directed stimulus for shift_load_sequencer
//               against a queue-based reference model and a word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_load_sequencer;

  localparam int DEPTH  = 4;
  localparam int PERIOD = 4;

  logic       Clk      = 1'b0;
  logic       Reset    = 1'b0;
  logic       In_Valid = 1'b0;
  logic [3:0] In_Data  = 4'h0;
  logic       In_Ready;
  logic       Load;
  logic [3:0] D;
  logic       Busy;
  logic [4:0] Level;
`ifdef SHIFT_SEQ_COUNT_EN
  logic [7:0] Load_Count;
`endif

  shift_load_sequencer #(
    .DEPTH  (DEPTH),
    .PERIOD (PERIOD)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .In_Valid   (In_Valid),
    .In_Data    (In_Data),
    .In_Ready   (In_Ready),
    .Load       (Load),
    .D          (D),
    .Busy       (Busy),
    .Level      (Level)
`ifdef SHIFT_SEQ_COUNT_EN
    ,
    .Load_Count (Load_Count)
`endif
  );

  always #5 Clk = ~Clk;

  int         total = 0;
  int         bad   = 0;

  // Reference model: the FIFO contents, the last slot start and the word
  // currently held on D. A slot may start once PERIOD edges have elapsed
  // since the previous slot start and the FIFO held a word before the edge.
  logic [3:0] mFifo[$];
  logic [3:0] scbQ[$];
  logic [3:0] mD;
  logic [3:0] monExp;
  int         lastLoad;
  int         cyc;
  int         mLoads;
  bit         mLoad;
  bit         lastPush;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mFifo.delete();
    scbQ.delete();
    mD       = 4'h0;
    lastLoad = -1000;
    mLoad    = 1'b0;
    mLoads   = 0;
  endtask

  task automatic checkOutputs();
    chk("Load",     8'(Load),     8'(mLoad));
    chk("D",        8'(D),        8'(mD));
    chk("Busy",     8'(Busy),     8'(cyc < lastLoad + PERIOD));
    chk("Level",    8'(Level),    8'(mFifo.size()));
    chk("In_Ready", 8'(In_Ready), 8'(mFifo.size() != DEPTH));
`ifdef SHIFT_SEQ_COUNT_EN
    chk("Load_Count", Load_Count, 8'(mLoads));
`endif
  endtask

  // One clock: advance the model with the inputs the DUT samples, then check.
  task automatic step();
    bit doPop;
    @(posedge Clk);
    cyc++;
    lastPush = In_Valid && (mFifo.size() != DEPTH);
    doPop    = (mFifo.size() != 0) && (cyc >= lastLoad + PERIOD);
    mLoad    = doPop;
    if (doPop) begin
      mD       = mFifo.pop_front();
      lastLoad = cyc;
      mLoads++;
    end
    if (lastPush) begin
      mFifo.push_back(In_Data);
      scbQ.push_back(In_Data);
    end
    #1 checkOutputs();
  endtask

  // Asynchronous reset applied between clock edges, checked immediately.
  task automatic asyncReset(input int holdNs);
    In_Valid = 1'b0;
    #2 Reset = 1'b1;
    modelReset();
    #1 checkOutputs();
    #(holdNs - 1) Reset = 1'b0;
  endtask

  // Offer one word until the model says it was accepted (bounded).
  task automatic sendWord(input logic [3:0] w);
    int n;
    In_Valid = 1'b1;
    In_Data  = w;
    n = 0;
    do begin
      step();
      n++;
    end while (!lastPush && n < 50);
    if (!lastPush) begin
      total++;
      bad++;
      $display("FAIL sendWord: word %0h not accepted within %0d cycles", w, n);
    end
    In_Valid = 1'b0;
  endtask

  // Scoreboard monitor: every Load strobe must present the oldest pending word.
  always @(posedge Clk) begin
    #2;
    if (!Reset && Load === 1'b1) begin
      total++;
      if (scbQ.size() == 0) begin
        bad++;
        $display("FAIL scoreboard: Load with D=%0h but no word pending", D);
      end else begin
        monExp = scbQ.pop_front();
        if (D !== monExp) begin
          bad++;
          $display("FAIL scoreboard D: got %0h expected %0h", D, monExp);
        end
      end
    end
  end

  initial begin
    cyc = 0;
    modelReset();
    asyncReset(20);

    // Single word into an idle sequencer
    In_Valid = 1'b1;
    In_Data  = 4'hA;
    step();
    In_Valid = 1'b0;
    repeat (8) step();

    // Back-to-back burst
    for (int i = 1; i <= 3; i++) begin
      In_Valid = 1'b1;
      In_Data  = 4'(i);
      step();
    end
    In_Valid = 1'b0;
    repeat (14) step();

    // Fill past capacity while the first slot is running
    for (int i = 0; i < 6; i++) begin
      In_Valid = 1'b1;
      In_Data  = 4'(4 + i);
      step();
    end
    In_Valid = 1'b0;
    repeat (30) step();

    // Stream across pointer wrap
    for (int i = 0; i < 20; i++) begin
      sendWord(4'(i % 16));
    end
    repeat (40) step();

    // Reset in the middle of a slot with words pending
    for (int i = 0; i < 3; i++) begin
      In_Valid = 1'b1;
      In_Data  = 4'(11 + i);
      step();
    end
    In_Valid = 1'b0;
    chk("Level before reset", 8'(Level), 8'd2);
    asyncReset(50);
    repeat (8) step();

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      In_Valid = ($urandom_range(0, 3) != 0);
      In_Data  = 4'($urandom);
      step();
    end
    In_Valid = 1'b0;
    repeat (30) step();

`ifdef SHIFT_SEQ_COUNT_EN
    // Load counter wrap after 260 slots
    asyncReset(20);
    begin
      int n;
      n = 0;
      while (mLoads < 260 && n < 2000) begin
        In_Valid = 1'b1;
        In_Data  = 4'($urandom);
        step();
        n++;
      end
    end
    In_Valid = 1'b0;
    chk("Load_Count after 260 loads", Load_Count, 8'd4);
    repeat (30) step();
`endif

    chk("scoreboard drained", 8'(scbQ.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_load_sequencer.md
SHIFT_LOAD_SEQUENCER -- requirements
Module: shift_load_sequencer

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, FIFO word capacity, power of two, range 2..16; PERIOD, default 4, clocks per load slot, range 2..255.
REQ-002 The module SHALL have these ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high.
- In_Valid  in  1  upstream word offered.
- In_Data  in  4  upstream word.
- In_Ready  out  1  FIFO can accept a word.
- Load  out  1  parallel-load strobe to the downstream 4-bit shift register.
- D  out  4  word presented with Load.
- Busy  out  1  sequencer not in IDLE.
- Level  out  5  FIFO occupancy, 0..DEPTH.
REQ-003 All outputs except In_Ready SHALL be registered; In_Ready = (Level != DEPTH), with no combinational path from any input.

Function
REQ-004 A push SHALL occur on a rising edge where In_Valid && In_Ready; In_Data is written at the tail.
REQ-005 The FSM SHALL have three states: IDLE, LOAD and SHIFT.
REQ-006 IDLE -> LOAD SHALL occur on the edge where Level != 0; that edge pops the head into D and sets Load=1.
REQ-007 LOAD SHALL last exactly one cycle (Load=1), then go to SHIFT with the slot counter = PERIOD-2; Load=0 in SHIFT and IDLE.
REQ-008 SHIFT SHALL decrement the counter each edge. When the counter is 0: if Level != 0, go to LOAD (pop, Load=1); else go to IDLE.
REQ-009 Consecutive Load pulses SHALL be exactly PERIOD cycles apart while the FIFO is non-empty; there are no idle gaps between slots.
REQ-010 Latency SHALL be fixed: with the sequencer in IDLE, a word pushed at edge N gives Load=1 and D=word after edge N+1.
REQ-011 D SHALL hold its last loaded value until the next LOAD; it SHALL NOT change in SHIFT or IDLE.
REQ-012 Simultaneous push and pop SHALL leave Level unchanged and keep FIFO order.
- A push into an empty FIFO at the same edge the FSM samples Level=0 SHALL NOT be popped on that edge.
REQ-013 When full, In_Ready=0 and In_Data SHALL be ignored.
- A pop on the same edge does not admit a word until the next cycle.
REQ-014 FIFO pointers SHALL wrap modulo DEPTH; Level SHALL never exceed DEPTH or underflow.
REQ-015 Busy SHALL be 1 in LOAD and SHIFT, and 0 in IDLE.

Reset
REQ-016 Reset asserted SHALL immediately force: state=IDLE, Load=0, D=4'b0000, Busy=0, Level=0, pointers=0, counter=0, In_Ready=1.
REQ-017 Reset mid-slot SHALL discard all FIFO contents and abort the current slot without a further Load pulse.
REQ-018 The first push SHALL be accepted on the first rising edge after Reset deasserts.

Configuration
REQ-019 With macro SHIFT_SEQ_COUNT_EN defined, an extra output Load_Count (8 bits, out) SHALL increment by 1 on every Load pulse, wrap from 255 to 0, and reset to 0.
REQ-020 Without SHIFT_SEQ_COUNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-021 Single word: after reset, push 4'hA at edge N -> Load=1 and D=4'hA after edge N+1 only; Busy=1 for 4 cycles, then IDLE.
REQ-022 Burst: push 4'h1, 4'h2, 4'h3 back-to-back (PERIOD=4) -> Load pulses 4 cycles apart with D=1, 2, 3 in order; Level returns to 0.
REQ-023 Full: push 5 words with DEPTH=4 while the sequencer is stalled in its first slot -> In_Ready=0 once Level=4, and the 5th word is held off until the next pop; no word is lost or duplicated.
REQ-024 Wrap: stream 20 words 4'h0..4'hF, 4'h0..4'h3 -> output order matches input across pointer wrap.
REQ-025 Reset mid-slot: assert Reset for 50 ns during SHIFT with Level=2 -> Load=0, D=0, Level=0 at once; no Load pulse until a new push.
REQ-026 Counter (SHIFT_SEQ_COUNT_EN): 260 loads -> Load_Count=4 (8-bit wrap from 255).
